// File: rtl/des_ks_pkg.sv
// Shared constants, types and the PC-2 selection table for the DES key schedule.
// The PC-2 helper is used by des_key_schedule only when DES_KS_PC2_EN is defined.
package des_ks_pkg;

    localparam int unsigned KS_HALF_W    = 28;
    localparam int unsigned KS_ROUNDS    = 16;
    localparam logic [15:0] KS_SHIFT_MAP = 16'h7EFC;
    localparam int unsigned CD_W         = 56;
    localparam int unsigned PC2_W        = 48;

    typedef enum logic [1:0] {
        KS_IDLE = 2'd0,
        KS_RUN  = 2'd1,
        KS_DONE = 2'd2
    } ks_state_t;

    typedef enum logic {
        ROT_LEFT  = 1'b0,
        ROT_RIGHT = 1'b1
    } rot_dir_t;

    // 1-based source bit positions into C||D, entry 0 selects the subkey MSB.
    localparam logic [5:0] PC2_TABLE [PC2_W] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    function automatic logic [PC2_W-1:0] pc2_compress(input logic [CD_W-1:0] cd);
        logic [PC2_W-1:0] sub;
        sub = '0;
        for (int k = 0; k < int'(PC2_W); k++) begin
            sub[int'(PC2_W) - 1 - k] = cd[int'(CD_W) - int'(PC2_TABLE[k])];
        end
        return sub;
    endfunction

endpackage

// File: rtl/des_key_rotator.sv
// Combinational rotate of one key half by 0, 1 or 2 positions in either direction.
module des_key_rotator
    import des_ks_pkg::*;
#(
    parameter int unsigned HALF_W = KS_HALF_W
) (
    input  logic [HALF_W-1:0] half,
    input  logic [1:0]        amount,
    input  rot_dir_t          direction,
    output logic [HALF_W-1:0] rotated_c
);

    always_comb begin
        rotated_c = half;
        case (amount)
            2'd1: begin
                if (direction == ROT_LEFT) begin
                    rotated_c = {half[HALF_W-2:0], half[HALF_W-1]};
                end else begin
                    rotated_c = {half[0], half[HALF_W-1:1]};
                end
            end
            2'd2: begin
                if (direction == ROT_LEFT) begin
                    rotated_c = {half[HALF_W-3:0], half[HALF_W-1:HALF_W-2]};
                end else begin
                    rotated_c = {half[1:0], half[HALF_W-1:2]};
                end
            end
            default: rotated_c = half;
        endcase
    end

endmodule

// File: rtl/des_key_schedule.sv
// DES key-schedule sequencer: loads C0/D0 once, then emits ROUNDS rotated C/D pairs
// under valid/ready. Define DES_KS_PC2_EN to add the combinational ks_subkey output.
module des_key_schedule
    import des_ks_pkg::*;
#(
    parameter int unsigned        HALF_W    = KS_HALF_W,
    parameter int unsigned        ROUNDS    = KS_ROUNDS,
    parameter logic [ROUNDS-1:0]  SHIFT_MAP = ROUNDS'(KS_SHIFT_MAP),
    localparam int unsigned       RW        = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ks_start,
    input  logic              ks_decrypt,
    input  logic [HALF_W-1:0] ks_left_in,
    input  logic [HALF_W-1:0] ks_right_in,
    input  logic              ks_ready,
    output logic [HALF_W-1:0] ks_left_out,
    output logic [HALF_W-1:0] ks_right_out,
    output logic [RW-1:0]     ks_round,
    output logic              ks_valid,
    output logic              ks_busy,
    output logic              ks_done
`ifdef DES_KS_PC2_EN
    ,
    output logic [47:0]       ks_subkey
`endif
);

    ks_state_t         state, state_nxt;
    rot_dir_t          mode, mode_nxt;
    logic [HALF_W-1:0] left_nxt, right_nxt;
    logic [RW-1:0]     round_nxt;
    logic              valid_nxt, busy_nxt, done_nxt;

    logic [HALF_W-1:0] rot_c_src, rot_d_src, rot_c, rot_d;
    logic [1:0]        rot_amt;
    rot_dir_t          rot_dir;
    logic [RW-1:0]     enc_idx, dec_idx;
    logic              last_round;

    function automatic logic [1:0] amt_of(input logic [RW-1:0] idx);
        return SHIFT_MAP[idx] ? 2'd2 : 2'd1;
    endfunction

    // Decrypt walks the map backwards so each decrypt step undoes one encrypt step.
    assign enc_idx    = ks_round + RW'(1);
    assign dec_idx    = RW'(ROUNDS - 1) - ks_round;
    assign last_round = (ks_round == RW'(ROUNDS - 1));

    des_key_rotator #(.HALF_W(HALF_W)) u_rot_c (
        .half      (rot_c_src),
        .amount    (rot_amt),
        .direction (rot_dir),
        .rotated_c (rot_c)
    );

    des_key_rotator #(.HALF_W(HALF_W)) u_rot_d (
        .half      (rot_d_src),
        .amount    (rot_amt),
        .direction (rot_dir),
        .rotated_c (rot_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= KS_IDLE;
            mode         <= ROT_LEFT;
            ks_left_out  <= '0;
            ks_right_out <= '0;
            ks_round     <= '0;
            ks_valid     <= 1'b0;
            ks_busy      <= 1'b0;
            ks_done      <= 1'b0;
        end else begin
            state        <= state_nxt;
            mode         <= mode_nxt;
            ks_left_out  <= left_nxt;
            ks_right_out <= right_nxt;
            ks_round     <= round_nxt;
            ks_valid     <= valid_nxt;
            ks_busy      <= busy_nxt;
            ks_done      <= done_nxt;
        end
    end

    // Next-state, rotator steering and registered-output updates.
    always_comb begin
        state_nxt = state;
        mode_nxt  = mode;
        left_nxt  = ks_left_out;
        right_nxt = ks_right_out;
        round_nxt = ks_round;
        valid_nxt = ks_valid;
        busy_nxt  = ks_busy;
        done_nxt  = 1'b0;
        rot_c_src = ks_left_out;
        rot_d_src = ks_right_out;
        rot_amt   = 2'd0;
        rot_dir   = mode;

        case (state)
            KS_IDLE: begin
                rot_c_src = ks_left_in;
                rot_d_src = ks_right_in;
                rot_dir   = rot_dir_t'(ks_decrypt);
                rot_amt   = ks_decrypt ? 2'd0 : amt_of(RW'(0));
                if (ks_start) begin
                    state_nxt = KS_RUN;
                    mode_nxt  = rot_dir_t'(ks_decrypt);
                    left_nxt  = rot_c;
                    right_nxt = rot_d;
                    round_nxt = '0;
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                end
            end
            KS_RUN: begin
                rot_amt = (mode == ROT_RIGHT) ? amt_of(dec_idx) : amt_of(enc_idx);
                if (ks_ready) begin
                    if (last_round) begin
                        state_nxt = KS_DONE;
                        left_nxt  = '0;
                        right_nxt = '0;
                        round_nxt = '0;
                        valid_nxt = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        left_nxt  = rot_c;
                        right_nxt = rot_d;
                        round_nxt = enc_idx;
                    end
                end
            end
            KS_DONE: begin
                state_nxt = KS_IDLE;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = KS_IDLE;
                left_nxt  = '0;
                right_nxt = '0;
                round_nxt = '0;
                valid_nxt = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

`ifdef DES_KS_PC2_EN
    if (HALF_W != 28) begin : g_pc2_width_check
        $error("des_key_schedule: PC-2 output requires HALF_W == 28");
    end

    always_comb begin
        ks_subkey = '0;
        if (ks_valid) begin
            ks_subkey = pc2_compress(CD_W'({ks_left_out, ks_right_out}));
        end
    end
`endif

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: closed-form rotation model plus directed
// and randomized handshake traffic. PC-2 checks are active when DES_KS_PC2_EN is defined.
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        rst, ks_start, ks_decrypt, ks_ready;
    logic [27:0] ks_left_in, ks_right_in, ks_left_out, ks_right_out;
    logic [3:0]  ks_round;
    logic        ks_valid, ks_busy, ks_done;
`ifdef DES_KS_PC2_EN
    logic [47:0] ks_subkey;
`endif

    always #5 clk = ~clk;

    des_key_schedule dut (
        .clk          (clk),
        .rst          (rst),
        .ks_start     (ks_start),
        .ks_decrypt   (ks_decrypt),
        .ks_left_in   (ks_left_in),
        .ks_right_in  (ks_right_in),
        .ks_ready     (ks_ready),
        .ks_left_out  (ks_left_out),
        .ks_right_out (ks_right_out),
        .ks_round     (ks_round),
        .ks_valid     (ks_valid),
        .ks_busy      (ks_busy),
`ifdef DES_KS_PC2_EN
        .ks_subkey    (ks_subkey),
`endif
        .ks_done      (ks_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: cumulative rotation computed directly from the shift map.
    localparam logic [15:0] MAP = 16'h7EFC;

    function automatic int amt(input int i);
        return MAP[i] ? 2 : 1;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input int n);
        logic [55:0] y;
        y = {x, x} << (n % 28);
        return y[55:28];
    endfunction

    function automatic logic [27:0] exp_half(input logic [27:0] x, input logic dec, input int r);
        int s;
        s = 0;
        if (!dec) begin
            for (int i = 0; i <= r; i++) s += amt(i);
            return rotl(x, s);
        end
        for (int j = 1; j <= r; j++) s += amt(16 - j);
        return rotl(x, 28 - (s % 28));
    endfunction

    // Protocol model: what the outputs must show after each edge.
    logic        m_valid = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_dec = 1'b0, m_clear = 1'b1;
    int          m_round = 0;
    logic [27:0] m_c0 = '0, m_d0 = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0; m_round <= 0; m_clear <= 1'b1;
        end else if (m_done) begin
            m_done <= 1'b0; m_busy <= 1'b0;
        end else if (m_valid) begin
            if (ks_ready) begin
                if (m_round == 15) begin
                    m_valid <= 1'b0; m_done <= 1'b1;
                end else begin
                    m_round <= m_round + 1;
                end
            end
        end else if (!m_busy && ks_start) begin
            m_c0 <= ks_left_in; m_d0 <= ks_right_in; m_dec <= ks_decrypt;
            m_valid <= 1'b1; m_busy <= 1'b1; m_round <= 0; m_clear <= 1'b0;
        end
    end

    logic cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("valid", 64'(ks_valid), 64'(m_valid));
            chk("busy", 64'(ks_busy), 64'(m_busy));
            chk("done", 64'(ks_done), 64'(m_done));
            if (m_valid) begin
                chk("round", 64'(ks_round), 64'(m_round));
                chk("left", 64'(ks_left_out), 64'(exp_half(m_c0, m_dec, m_round)));
                chk("right", 64'(ks_right_out), 64'(exp_half(m_d0, m_dec, m_round)));
            end else if (m_clear) begin
                chk("idle_round", 64'(ks_round), 64'(0));
                chk("idle_left", 64'(ks_left_out), 64'(0));
                chk("idle_right", 64'(ks_right_out), 64'(0));
            end
`ifdef DES_KS_PC2_EN
            if (!m_valid) chk("subkey_idle", 64'(ks_subkey), 64'(0));
`endif
        end
    end

    task automatic do_start(input logic [27:0] c, input logic [27:0] d, input logic dec);
        int n;
        n = 0;
        while (ks_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("start_wait_idle", 64'(1), 64'(0));
        ks_left_in = c; ks_right_in = d; ks_decrypt = dec; ks_start = 1'b1;
        @(posedge clk);
        #1;
        ks_start    = 1'b0;
        ks_left_in  = 28'($urandom);
        ks_right_in = 28'($urandom);
        ks_decrypt  = 1'($urandom);
    endtask

    task automatic wait_round(input int r);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(negedge clk);
            if (ks_valid && ks_round == 4'(r)) found = 1'b1;
        end
        if (!found) chk("wait_round_timeout", 64'(r), 64'(999));
    endtask

    logic [27:0] cap_c [16];
    logic [27:0] cap_d [16];
    int          cap_n;
    logic        cap_done_after_last;

    task automatic capture();
        logic seen_done, prev_last;
        seen_done = 1'b0; prev_last = 1'b0; cap_n = 0; cap_done_after_last = 1'b0;
        for (int cyc = 0; cyc < 200 && !seen_done; cyc++) begin
            @(negedge clk);
            if (ks_valid) begin
                cap_c[ks_round] = ks_left_out;
                cap_d[ks_round] = ks_right_out;
                cap_n++;
            end
            if (ks_done) begin
                seen_done = 1'b1;
                cap_done_after_last = prev_last;
            end
            prev_last = ks_valid && (ks_round == 4'd15);
        end
        chk("done_seen", 64'(seen_done), 64'(1));
    endtask

    initial begin
        logic [27:0] c, d, hold_c, hold_d;
        logic        fin;

        rst = 1'b1; ks_start = 1'b0; ks_decrypt = 1'b0; ks_ready = 1'b1;
        ks_left_in = '0; ks_right_in = '0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_valid", 64'(ks_valid), 64'(0));
        chk("rst_busy", 64'(ks_busy), 64'(0));
        chk("rst_left", 64'(ks_left_out), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Encrypt directed vector
        do_start(28'h0000001, 28'h8000000, 1'b0);
        capture();
        chk("enc_valid_cycles", 64'(cap_n), 64'(16));
        chk("enc_done_after_r15", 64'(cap_done_after_last), 64'(1));
        chk("enc_r0_c", 64'(cap_c[0]), 64'h0000002);
        chk("enc_r0_d", 64'(cap_d[0]), 64'h0000001);
        chk("enc_r2_c", 64'(cap_c[2]), 64'h0000010);
        chk("enc_r15_c", 64'(cap_c[15]), 64'h0000001);
        chk("enc_r15_d", 64'(cap_d[15]), 64'h8000000);

        // Decrypt directed vector; round r mirrors encrypt round 15-r
        do_start(28'h0000001, 28'h8000000, 1'b1);
        capture();
        chk("dec_valid_cycles", 64'(cap_n), 64'(16));
        chk("dec_r0_c", 64'(cap_c[0]), 64'h0000001);
        chk("dec_r1_c", 64'(cap_c[1]), 64'h8000000);
        chk("dec_r2_c", 64'(cap_c[2]), 64'h2000000);
        for (int r = 1; r < 16; r++) begin
            chk("dec_mirror_c", 64'(cap_c[r]), 64'(exp_half(28'h0000001, 1'b0, 15 - r)));
            chk("dec_mirror_d", 64'(cap_d[r]), 64'(exp_half(28'h8000000, 1'b0, 15 - r)));
        end

        // Backpressure at round 3
        c = 28'($urandom); d = 28'($urandom);
        do_start(c, d, 1'b0);
        wait_round(3);
        ks_ready = 1'b0;
        hold_c = ks_left_out; hold_d = ks_right_out;
        repeat (5) begin
            @(negedge clk);
            chk("stall_round", 64'(ks_round), 64'(3));
            chk("stall_c", 64'(ks_left_out), 64'(hold_c));
            chk("stall_d", 64'(ks_right_out), 64'(hold_d));
        end
        ks_ready = 1'b1;
        @(negedge clk);
        chk("resume_round", 64'(ks_round), 64'(4));
        chk("resume_c", 64'(ks_left_out), 64'(exp_half(c, 1'b0, 4)));

        // Start while busy must be ignored
        c = 28'($urandom); d = 28'($urandom);
        do_start(c, d, 1'b0);
        wait_round(7);
        ks_start = 1'b1; ks_left_in = ~c; ks_right_in = ~d; ks_decrypt = 1'b1;
        @(negedge clk);
        ks_start = 1'b0;
        wait_round(15);
        chk("busy_start_r15_c", 64'(ks_left_out), 64'(c));
        chk("busy_start_r15_d", 64'(ks_right_out), 64'(d));

        // Reset in the middle of a run
        c = 28'($urandom); d = 28'($urandom);
        do_start(c, d, 1'b1);
        wait_round(9);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_valid", 64'(ks_valid), 64'(0));
        chk("midrst_busy", 64'(ks_busy), 64'(0));
        chk("midrst_done", 64'(ks_done), 64'(0));
        chk("midrst_c", 64'(ks_left_out), 64'(0));
        @(negedge clk);
        chk("midrst_no_done", 64'(ks_done), 64'(0));
        c = 28'($urandom); d = 28'($urandom);
        do_start(c, d, 1'b0);
        wait_round(0);
        chk("fresh_r0_c", 64'(ks_left_out), 64'(rotl(c, 1)));
        chk("fresh_r0_d", 64'(ks_right_out), 64'(rotl(d, 1)));
        wait_round(15);

`ifdef DES_KS_PC2_EN
        do_start(28'hFFFFFFF, 28'hFFFFFFF, 1'b0);
        for (int r = 0; r < 16; r++) begin
            wait_round(r);
            chk("pc2_ones", 64'(ks_subkey), 64'hFFFFFFFFFFFF);
        end
        do_start(28'hF0CCAAF, 28'h556678F, 1'b0);
        wait_round(0);
        chk("pc2_fips_k1", 64'(ks_subkey), 64'h1B02EFFC7072);
        wait_round(15);
`endif

        // Randomized traffic with random backpressure and stray starts
        for (int it = 0; it < 25; it++) begin
            do_start(28'($urandom), 28'($urandom), 1'($urandom));
            fin = 1'b0;
            for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
                @(negedge clk);
                if (ks_done) begin
                    fin = 1'b1;
                end else begin
                    ks_ready = ($urandom_range(0, 3) != 0);
                    ks_start = ($urandom_range(0, 15) == 0);
                    ks_left_in = 28'($urandom); ks_right_in = 28'($urandom);
                    ks_decrypt = 1'($urandom);
                end
            end
            ks_start = 1'b0;
            ks_ready = 1'b1;
            if (!fin) chk("random_run_timeout", 64'(0), 64'(1));
        end

        repeat (3) @(negedge clk);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
- Parametrised key-schedule sequencer for the DES datapath; successor to the fixed single-step 2-bit key-half rotator.
- Loads the post-PC-1 C/D halves once, then emits ROUNDS successive rotated C/D pairs, one per accepted handshake.
- Per-round shift amount comes from a schedule map. Supports encrypt (left rotate) and decrypt (right rotate) modes.
- Has valid/ready output backpressure. Sits between PC-1 and PC-2/round logic.

Parameters:
- HALF_W, 28, width of each key half (C and D).
- ROUNDS, 16, number of subkeys produced per start.
- SHIFT_MAP, 16'h7EFC, ROUNDS bits; bit i=1 means encrypt round i rotates by 2, bit i=0 means it rotates by 1.
- RW, $clog2(ROUNDS), round index width (derived).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- ks_start  in  1  start request, sampled in IDLE only
- ks_decrypt  in  1  mode, latched with ks_start (1 = decrypt order)
- ks_left_in  in  HALF_W  C0 half
- ks_right_in  in  HALF_W  D0 half
- ks_ready  in  1  consumer accepts current round output
- ks_left_out  out  HALF_W  current round C half
- ks_right_out  out  HALF_W  current round D half
- ks_round  out  RW  current round index, 0..ROUNDS-1
- ks_valid  out  1  outputs hold a valid round key pair
- ks_busy  out  1  high from start acceptance until done
- ks_done  out  1  one-cycle pulse after final round is accepted

Behaviour:
- Single clock clk. Synchronous active-high rst: all state updates only on the rising edge of clk.
- Reset values: all outputs 0 (no X on outputs ever); state IDLE; internal mode 0.
- States:
  - IDLE: waiting for ks_start.
  - RUN: presenting round keys.
  - DONE: single cycle, ks_done=1, ks_valid=0, ks_busy=1; then returns to IDLE.
- Rotation convention:
  - Left rotate by n moves the n MSBs to the LSB end, i.e. {x[HALF_W-n-1:0], x[HALF_W-1:HALF_W-n]}.
  - Right rotate is the inverse.
- Shift amount: amt(i) = SHIFT_MAP[i] ? 2 : 1.
- IDLE + ks_start:
  - Latch ks_decrypt.
  - Load C/D pre-rotated for round 0: encrypt uses left rotate by amt(0); decrypt uses no rotation.
  - Set round=0, go to RUN.
  - ks_valid and ks_busy go high the following cycle (latency 1).
- RUN, ks_valid && !ks_ready: hold all outputs unchanged (stall, no limit).
- RUN, ks_valid && ks_ready, round<ROUNDS-1:
  - round+1.
  - Encrypt: rotate left by amt(round+1).
  - Decrypt: rotate right by amt(ROUNDS-(round+1)).
  - ks_valid stays high, so back-to-back throughput is one key per cycle.
- RUN, handshake at round=ROUNDS-1: go to DONE. ks_valid drops next cycle.
- ks_start while busy (RUN/DONE): ignored. A start in the same cycle as the DONE pulse is also ignored; it is accepted only in IDLE.
- Round index wraps never: ROUNDS-1 is terminal.
- With the default SHIFT_MAP, cumulative encrypt rotation is 28, so round 15 output equals the inputs.
- rst mid-operation: immediate return to IDLE on that edge; outputs cleared; no ks_done pulse.
- Input halves are sampled only at start acceptance; changes afterwards have no effect.

Optional Feature:
- Macro: DES_KS_PC2_EN.
- Defined:
  - Adds output ks_subkey [47:0], the combinational PC-2 compression of {ks_left_out, ks_right_out}. Zero when ks_valid=0.
  - HALF_W must be 28; otherwise elaboration error.
- Undefined: port absent; only C/D halves are output.

Decomposition:
- Package des_ks_pkg: default HALF_W/ROUNDS/SHIFT_MAP constants, state enum (IDLE/RUN/DONE), PC-2 index table (48 entries).
- Sub-module des_key_rotator: purely combinational. Inputs: half, amount (0/1/2), direction. Output: rotated half. Instantiated twice (C and D).

Test Plan:
- Encrypt, C=28'h0000001, D=28'h8000000, ready=1 → round0 C=28'h0000002, D=28'h0000001; round2 C=28'h0000010. Round15 C/D equal inputs. ks_done pulses the cycle after round15 handshake. 16 consecutive valid cycles.
- Decrypt, C=28'h0000001 → round0 C=28'h0000001 (no shift); round1 C=28'h8000000; round2 C=28'h2000000. Each decrypt round r≥1 equals encrypt round 15-r from the same inputs.
- Backpressure: ready=0 for 5 cycles at round 3 → ks_round=3 and C/D stable throughout. Resume gives round 4 with the correct shift; no round skipped or repeated.
- ks_start pulsed at round 7 with different inputs and mode → ignored; sequence completes with the original key.
- rst asserted at round 9 → next cycle ks_valid=0, ks_busy=0, outputs 0, no ks_done. A new start gives round0 from the fresh inputs.
- DES_KS_PC2_EN defined, C=D=0xFFFFFFF → ks_subkey=48'hFFFFFFFFFFFF for all rounds. Known FIPS-46 vector key 133457799BBCDFF1 → round0 subkey 48'h1B02EFFC7072.
